pipe_ctl_chain: RTL
===================

Name: pipe_ctl_chain

Overview:
- Consumer/responder side of the ID-stage control/hazard interface in the 5-stage MIPS pipeline.
- Takes the decoded control bundle from ID each cycle and resolves the destination register.
- Carries the bundle through the ID/EXE, EXE/MEM and MEM/WB control registers.
- Returns the EXE/MEM-side status (e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn) that ID uses for forwarding and load-use stall.
- Handles bubble insertion, flush and memory-wait freeze.

Parameters:
- RN_W, 5: register-number width.
- LINK_REG, 31: destination for jal.
- PERF_W, 32: performance counter width (optional feature only).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  synchronous active-low reset.
- d_wreg  in  1  ID: register write enable (already gated by nostall in ID).
- d_m2reg  in  1  ID: writeback from memory.
- d_wmem  in  1  ID: memory write.
- d_jal  in  1  ID: jump-and-link.
- d_regrt  in  1  ID: destination is rt.
- d_rd  in  RN_W  ID: rd field.
- d_rt  in  RN_W  ID: rt field.
- nostall  in  1  ID: 0 = load-use hazard, bubble into EXE.
- flush  in  1  1-cycle pulse: kill instruction entering EXE.
- mem_wait  in  1  data memory not ready: freeze EXE and MEM.
- e_wreg, e_m2reg, e_wmem, e_jal  out  1 each  EXE-stage controls.
- e_rn  out  RN_W  EXE destination register.
- m_wreg, m_m2reg, m_wmem  out  1 each  MEM-stage controls.
- m_rn  out  RN_W  MEM destination register.
- w_wreg, w_m2reg  out  1 each  WB-stage controls.
- w_rn  out  RN_W  WB destination register.
- stall_cnt, wait_cnt, retire_cnt  out  PERF_W each  performance counters.

Behaviour:
- Reset (resetn=0 at edge): all outputs 0, all valid bits 0, pending flush cleared. Reset overrides every other input.
- Destination resolve (combinational, at EXE capture): d_jal → LINK_REG; else d_regrt → d_rt; else d_rd.
- Bubble definition: wreg=m2reg=wmem=jal=0, rn=0, valid=0.
- Each stage holds an internal valid bit.
- EXE register next state, priority order:
  1. mem_wait=1: hold.
  2. flush=1 or pending flush set: bubble; clear pending.
  3. nostall=0: bubble.
  4. Otherwise: capture the d_* bundle with valid=1.
- MEM register: mem_wait=1 → hold; else capture EXE.
- WB register: mem_wait=1 → bubble (no duplicate writeback); else capture MEM.
- Flush during mem_wait: set pending flush. On the first cycle with mem_wait=0, apply it as a flush. Multiple flushes while waiting collapse to one.
- Latency: an ID bundle appears on e_* 1 cycle after capture, on m_* after 2 and on w_* after 3, plus any mem_wait cycles.
- Bubble rn=0 guarantees ern!=0 qualification in ID fails even if wreg is mis-gated.
- e_*/m_*/w_* are direct register outputs; no combinational path from d_* to outputs.
- mem_wait held indefinitely: EXE/MEM hold stable, WB emits bubbles every cycle.
- Reset asserted mid-wait clears everything, including pending flush.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with nostall=0 and mem_wait=0.
  - wait_cnt increments each cycle with mem_wait=1.
  - retire_cnt increments each cycle the WB stage holds valid=1.
  - All three counters saturate at all-ones and clear on reset.
- Undefined: no counter logic; ports stay present and are tied to 0.

Test Plan:
- add with rd=5, regrt=0, wreg=1, nostall=1 for 1 cycle, then idle → e_rn=5, e_wreg=1 at cycle 1; m_rn=5 at cycle 2; w_rn=5, w_wreg=1 at cycle 3; all 0 afterwards.
- jal, d_rd=7, d_rt=9 → e_rn=31, e_jal=1. Then lw with regrt=1, rt=9 → e_rn=9, e_m2reg=1.
- lw to rt=8 followed by a cycle with nostall=0 → next cycle e_wreg=0, e_rn=0, m_rn=8, m_m2reg=1. Bubble reaches WB one cycle after the lw.
- mem_wait=1 for 3 cycles with sw in MEM (m_wmem=1) → m_wmem and e_* stable for 3 cycles, w_wreg=0 for 3 cycles. Pipeline resumes on the 4th cycle with no lost or duplicated instruction.
- flush pulse during mem_wait, wait ends 2 cycles later → first post-wait EXE capture is a bubble even with nostall=1. Following instruction captured normally.
- With PIPE_PERF_EN: 4 real instructions, 2 nostall=0 cycles, 3 mem_wait cycles → retire_cnt=4, stall_cnt=2, wait_cnt=3. resetn=0 clears all three to 0.

Source files
------------

// File: rtl/pipe_ctl_chain.sv
// pipe_ctl_chain
//   Responder side of the ID-stage control/hazard interface of a 5-stage MIPS
//   pipeline. Resolves the destination register of the decoded ID bundle and
//   carries it through the ID/EXE, EXE/MEM and MEM/WB control registers, with
//   load-use bubbles, flush (including flush deferred across a memory wait)
//   and memory-wait freeze. EXE and MEM status goes back to ID for forwarding
//   and stall detection.
//
//   Optional feature: define PIPE_PERF_EN to build the saturating stall, wait
//   and retire counters. Without it the counter ports are tied to zero.
module pipe_ctl_chain #(
  parameter int RN_W     = 5,
  parameter int LINK_REG = 31,
  parameter int PERF_W   = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              d_wreg,
  input  logic              d_m2reg,
  input  logic              d_wmem,
  input  logic              d_jal,
  input  logic              d_regrt,
  input  logic [RN_W-1:0]   d_rd,
  input  logic [RN_W-1:0]   d_rt,
  input  logic              nostall,
  input  logic              flush,
  input  logic              mem_wait,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic              e_jal,
  output logic [RN_W-1:0]   e_rn,
  output logic              m_wreg,
  output logic              m_m2reg,
  output logic              m_wmem,
  output logic [RN_W-1:0]   m_rn,
  output logic              w_wreg,
  output logic              w_m2reg,
  output logic [RN_W-1:0]   w_rn,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] wait_cnt,
  output logic [PERF_W-1:0] retire_cnt
);

  localparam logic [RN_W-1:0] LINK_RN = RN_W'(LINK_REG);

  logic            e_wreg_q, e_m2reg_q, e_wmem_q, e_jal_q, e_valid_q;
  logic            e_wreg_d, e_m2reg_d, e_wmem_d, e_jal_d, e_valid_d;
  logic [RN_W-1:0] e_rn_q, e_rn_d;
  logic            flush_pend_q, flush_pend_d;

  logic            m_wreg_q, m_m2reg_q, m_wmem_q, m_valid_q;
  logic            m_wreg_d, m_m2reg_d, m_wmem_d, m_valid_d;
  logic [RN_W-1:0] m_rn_q, m_rn_d;

  logic            w_wreg_q, w_m2reg_q;
  logic            w_wreg_d, w_m2reg_d;
  logic [RN_W-1:0] w_rn_q, w_rn_d;

  logic [RN_W-1:0] d_rn;

  // Destination of the instruction leaving ID: jal links, else rt or rd.
  always_comb begin
    if (d_jal) begin
      d_rn = LINK_RN;
    end else if (d_regrt) begin
      d_rn = d_rt;
    end else begin
      d_rn = d_rd;
    end
  end

  // EXE next state: wait freezes (and remembers a flush), then flush, then load-use bubble.
  always_comb begin
    e_wreg_d     = e_wreg_q;
    e_m2reg_d    = e_m2reg_q;
    e_wmem_d     = e_wmem_q;
    e_jal_d      = e_jal_q;
    e_rn_d       = e_rn_q;
    e_valid_d    = e_valid_q;
    flush_pend_d = flush_pend_q;
    if (mem_wait) begin
      // Several flushes during one wait collapse into a single pending bit.
      flush_pend_d = flush_pend_q | flush;
    end else if (flush || flush_pend_q || !nostall) begin
      // Bubble carries rn=0 so ID's rn!=0 qualification can never match it.
      e_wreg_d     = 1'b0;
      e_m2reg_d    = 1'b0;
      e_wmem_d     = 1'b0;
      e_jal_d      = 1'b0;
      e_rn_d       = '0;
      e_valid_d    = 1'b0;
      flush_pend_d = 1'b0;
    end else begin
      e_wreg_d     = d_wreg;
      e_m2reg_d    = d_m2reg;
      e_wmem_d     = d_wmem;
      e_jal_d      = d_jal;
      e_rn_d       = d_rn;
      e_valid_d    = 1'b1;
    end
  end

  // MEM next state: frozen while memory is busy, otherwise follows EXE.
  always_comb begin
    m_wreg_d  = m_wreg_q;
    m_m2reg_d = m_m2reg_q;
    m_wmem_d  = m_wmem_q;
    m_rn_d    = m_rn_q;
    m_valid_d = m_valid_q;
    if (!mem_wait) begin
      m_wreg_d  = e_wreg_q;
      m_m2reg_d = e_m2reg_q;
      m_wmem_d  = e_wmem_q;
      m_rn_d    = e_rn_q;
      m_valid_d = e_valid_q;
    end
  end

  // WB next state: bubble during a wait so the held MEM slot is written back only once.
  always_comb begin
    w_wreg_d  = 1'b0;
    w_m2reg_d = 1'b0;
    w_rn_d    = '0;
    if (!mem_wait) begin
      w_wreg_d  = m_wreg_q & m_valid_q;
      w_m2reg_d = m_m2reg_q;
      w_rn_d    = m_rn_q;
    end
  end

  // Pipeline control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      e_wreg_q     <= 1'b0;
      e_m2reg_q    <= 1'b0;
      e_wmem_q     <= 1'b0;
      e_jal_q      <= 1'b0;
      e_rn_q       <= '0;
      e_valid_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      m_wreg_q     <= 1'b0;
      m_m2reg_q    <= 1'b0;
      m_wmem_q     <= 1'b0;
      m_rn_q       <= '0;
      m_valid_q    <= 1'b0;
      w_wreg_q     <= 1'b0;
      w_m2reg_q    <= 1'b0;
      w_rn_q       <= '0;
    end else begin
      e_wreg_q     <= e_wreg_d;
      e_m2reg_q    <= e_m2reg_d;
      e_wmem_q     <= e_wmem_d;
      e_jal_q      <= e_jal_d;
      e_rn_q       <= e_rn_d;
      e_valid_q    <= e_valid_d;
      flush_pend_q <= flush_pend_d;
      m_wreg_q     <= m_wreg_d;
      m_m2reg_q    <= m_m2reg_d;
      m_wmem_q     <= m_wmem_d;
      m_rn_q       <= m_rn_d;
      m_valid_q    <= m_valid_d;
      w_wreg_q     <= w_wreg_d;
      w_m2reg_q    <= w_m2reg_d;
      w_rn_q       <= w_rn_d;
    end
  end

  assign e_wreg  = e_wreg_q;
  assign e_m2reg = e_m2reg_q;
  assign e_wmem  = e_wmem_q;
  assign e_jal   = e_jal_q;
  assign e_rn    = e_rn_q;
  assign m_wreg  = m_wreg_q;
  assign m_m2reg = m_m2reg_q;
  assign m_wmem  = m_wmem_q;
  assign m_rn    = m_rn_q;
  assign w_wreg  = w_wreg_q;
  assign w_m2reg = w_m2reg_q;
  assign w_rn    = w_rn_q;

`ifdef PIPE_PERF_EN
  // The WB valid bit is only observable through the retire counter.
  logic              w_valid_q, w_valid_d;
  logic [PERF_W-1:0] stall_cnt_q, wait_cnt_q, retire_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d, wait_cnt_d, retire_cnt_d;

  // Counter next state: saturating increments on their qualifying events.
  always_comb begin
    w_valid_d    = mem_wait ? 1'b0 : m_valid_q;
    stall_cnt_d  = stall_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (!nostall && !mem_wait && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (mem_wait && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + PERF_W'(1);
    end
    if (w_valid_q && (retire_cnt_q != '1)) begin
      retire_cnt_d = retire_cnt_q + PERF_W'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      w_valid_q    <= 1'b0;
      stall_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      w_valid_q    <= w_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign wait_cnt   = wait_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign stall_cnt  = '0;
  assign wait_cnt   = '0;
  assign retire_cnt = '0;
`endif

endmodule
